// File: rtl/dcache_lsu_pkg.sv
// Shared definitions for the dcache load/store unit: funct3 codes, word lengths,
// error codes, FSM states and the latched request control word.
package dcache_lsu_pkg;

  localparam int unsigned LANE_BITS = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    WL_BYTE = 2'd0,
    WL_HALF = 2'd1,
    WL_WORD = 2'd2
  } wordlen_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_MISALIGN  = 2'b01,
    ERR_CONFLICT  = 2'b10,
    ERR_TIMEOUT   = 2'b11
  } errcode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic       is_load;
    logic [2:0] funct3;
  } lsu_ctl_t;

endpackage

// File: rtl/dcache_lsu_align.sv
// Combinational lane logic: request alignment check, store byte/half replication,
// and load extraction with sign/zero extension.
module dcache_lsu_align
  import dcache_lsu_pkg::*;
#(
  parameter int unsigned DATABITS = 32
) (
  input  logic [1:0]          req_addr_lo,
  input  logic [2:0]          req_funct3,
  input  logic [DATABITS-1:0] req_wdata,
  input  logic [1:0]          rsp_addr_lo,
  input  logic [2:0]          rsp_funct3,
  input  logic [DATABITS-1:0] rsp_raw,
  output logic                misaligned_c,
  output logic [DATABITS-1:0] store_data_c,
  output logic [DATABITS-1:0] load_data_c
);

  logic [LANE_BITS-1:0] wd32;
  logic [LANE_BITS-1:0] raw32;
  logic [LANE_BITS-1:0] byte_sh;
  logic [LANE_BITS-1:0] half_sh;
  logic [LANE_BITS-1:0] st32;
  logic [LANE_BITS-1:0] ld32;

  always_comb begin
    wd32    = req_wdata[LANE_BITS-1:0];
    raw32   = rsp_raw[LANE_BITS-1:0];
    byte_sh = raw32 >> {rsp_addr_lo, 3'b000};
    half_sh = raw32 >> {rsp_addr_lo[1], 4'b0000};

    // Reserved funct3 encodings fall into the misaligned bucket.
    case (req_funct3)
      F3_B, F3_BU: misaligned_c = 1'b0;
      F3_H, F3_HU: misaligned_c = req_addr_lo[0];
      F3_W:        misaligned_c = |req_addr_lo;
      default:     misaligned_c = 1'b1;
    endcase

    case (req_funct3[1:0])
      WL_BYTE: st32 = {4{wd32[7:0]}};
      WL_HALF: st32 = {2{wd32[15:0]}};
      default: st32 = wd32;
    endcase

    case (rsp_funct3)
      F3_B:    ld32 = {{24{byte_sh[7]}}, byte_sh[7:0]};
      F3_BU:   ld32 = {24'd0, byte_sh[7:0]};
      F3_H:    ld32 = {{16{half_sh[15]}}, half_sh[15:0]};
      F3_HU:   ld32 = {16'd0, half_sh[15:0]};
      default: ld32 = raw32;
    endcase

    store_data_c = DATABITS'(st32);
    load_data_c  = DATABITS'(ld32);
  end

endmodule

// File: rtl/dcache_lsu.sv
// Load/store unit in front of the dcache: one transaction in flight, request held
// until hit, watchdog-guarded, with misalignment/conflict/timeout error reporting.
module dcache_lsu
  import dcache_lsu_pkg::*;
#(
  parameter int unsigned DATABITS    = 32,
  parameter int unsigned ADDRBITS    = 32,
  parameter int unsigned TIMEOUTBITS = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDRBITS-1:0] lsu_addr,
  input  logic [DATABITS-1:0] lsu_wdata,
  input  logic [2:0]          lsu_funct3,
  input  logic                lsu_rdreq,
  input  logic                lsu_wrreq,
  output logic [DATABITS-1:0] lsu_rdata,
  output logic                lsu_done,
  output logic                lsu_error,
  output logic [1:0]          lsu_errcode,
  output logic                lsu_busy,
  output logic [ADDRBITS-1:0] dcache_addr,
  output logic [DATABITS-1:0] dcache_in,
  input  logic [DATABITS-1:0] dcache_out,
  input  logic                dcache_valid,
  input  logic                dcache_busy,
  output logic                dcache_rdreq,
  output logic                dcache_wrreq,
  output logic [1:0]          dcache_wordlen
);

  state_e                 state_q, state_d;
  lsu_ctl_t               ctl_q, ctl_d;
  logic [ADDRBITS-1:0]    addr_q, addr_d;
  logic [DATABITS-1:0]    din_q, din_d;
  logic [1:0]             wordlen_q, wordlen_d;
  logic [TIMEOUTBITS-1:0] wdog_q, wdog_d, wdog_inc;
  logic [1:0]             errcode_q, errcode_d;
  logic [DATABITS-1:0]    rdata_q, rdata_d;
  logic                   rdreq_q, rdreq_d;
  logic                   wrreq_q, wrreq_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   busy_q, busy_d;

  logic                   misaligned;
  logic [DATABITS-1:0]    store_data;
  logic [DATABITS-1:0]    load_data;

  dcache_lsu_align #(.DATABITS(DATABITS)) u_align (
    .req_addr_lo  (lsu_addr[1:0]),
    .req_funct3   (lsu_funct3),
    .req_wdata    (lsu_wdata),
    .rsp_addr_lo  (addr_q[1:0]),
    .rsp_funct3   (ctl_q.funct3),
    .rsp_raw      (dcache_out),
    .misaligned_c (misaligned),
    .store_data_c (store_data),
    .load_data_c  (load_data)
  );

  always_comb begin
    state_d   = state_q;
    ctl_d     = ctl_q;
    addr_d    = addr_q;
    din_d     = din_q;
    wordlen_d = wordlen_q;
    wdog_d    = wdog_q;
    errcode_d = errcode_q;
    rdata_d   = '0;
    rdreq_d   = 1'b0;
    wrreq_d   = 1'b0;
    done_d    = 1'b0;
    error_d   = 1'b0;
    wdog_inc  = wdog_q + TIMEOUTBITS'(1);

    case (state_q)
      ST_IDLE: begin
        if (lsu_rdreq && lsu_wrreq) begin
          state_d   = ST_DONE;
          errcode_d = ERR_CONFLICT;
          done_d    = 1'b1;
          error_d   = 1'b1;
        end else if (lsu_rdreq || lsu_wrreq) begin
          ctl_d.is_load = lsu_rdreq;
          ctl_d.funct3  = lsu_funct3;
          addr_d        = lsu_addr;
          din_d         = store_data;
          wordlen_d     = lsu_funct3[1:0];
          if (misaligned) begin
            state_d   = ST_DONE;
            errcode_d = ERR_MISALIGN;
            done_d    = 1'b1;
            error_d   = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            rdreq_d = lsu_rdreq;
            wrreq_d = lsu_wrreq;
          end
        end
      end
      ST_ACCESS: begin
        // A hit wins over a watchdog expiry landing in the same cycle.
        if (dcache_valid && !dcache_busy) begin
          state_d   = ST_DONE;
          errcode_d = ERR_NONE;
          done_d    = 1'b1;
          rdata_d   = ctl_q.is_load ? load_data : '0;
        end else if (wdog_inc == {TIMEOUTBITS{1'b1}}) begin
          state_d   = ST_DONE;
          errcode_d = ERR_TIMEOUT;
          done_d    = 1'b1;
          error_d   = 1'b1;
        end else begin
          wdog_d  = wdog_inc;
          rdreq_d = rdreq_q;
          wrreq_d = wrreq_q;
        end
      end
      ST_DONE: begin
        wdog_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ctl_q     <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      wordlen_q <= '0;
      wdog_q    <= '0;
      errcode_q <= '0;
      rdata_q   <= '0;
      rdreq_q   <= 1'b0;
      wrreq_q   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctl_q     <= ctl_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      wordlen_q <= wordlen_d;
      wdog_q    <= wdog_d;
      errcode_q <= errcode_d;
      rdata_q   <= rdata_d;
      rdreq_q   <= rdreq_d;
      wrreq_q   <= wrreq_d;
      done_q    <= done_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
    end
  end

  assign lsu_rdata      = rdata_q;
  assign lsu_done       = done_q;
  assign lsu_error      = error_q;
  assign lsu_errcode    = errcode_q;
  assign lsu_busy       = busy_q;
  assign dcache_addr    = addr_q;
  assign dcache_in      = din_q;
  assign dcache_rdreq   = rdreq_q;
  assign dcache_wrreq   = wrreq_q;
  assign dcache_wordlen = wordlen_q;

endmodule

// File: tb/tb_dcache_lsu.sv
// Randomized scoreboard bench for dcache_lsu with a behavioural dcache responder.
module tb_dcache_lsu;

  localparam int TOB    = 6;
  localparam int TO_LAT = 1 << TOB;

  logic        clk;
  logic        reset_n;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [2:0]  lsu_funct3;
  logic        lsu_rdreq;
  logic        lsu_wrreq;
  logic [31:0] lsu_rdata;
  logic        lsu_done;
  logic        lsu_error;
  logic [1:0]  lsu_errcode;
  logic        lsu_busy;
  logic [31:0] dcache_addr;
  logic [31:0] dcache_in;
  logic [31:0] dcache_out;
  logic        dcache_valid;
  logic        dcache_busy;
  logic        dcache_rdreq;
  logic        dcache_wrreq;
  logic [1:0]  dcache_wordlen;

  dcache_lsu #(.DATABITS(32), .ADDRBITS(32), .TIMEOUTBITS(TOB)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .lsu_addr       (lsu_addr),
    .lsu_wdata      (lsu_wdata),
    .lsu_funct3     (lsu_funct3),
    .lsu_rdreq      (lsu_rdreq),
    .lsu_wrreq      (lsu_wrreq),
    .lsu_rdata      (lsu_rdata),
    .lsu_done       (lsu_done),
    .lsu_error      (lsu_error),
    .lsu_errcode    (lsu_errcode),
    .lsu_busy       (lsu_busy),
    .dcache_addr    (dcache_addr),
    .dcache_in      (dcache_in),
    .dcache_out     (dcache_out),
    .dcache_valid   (dcache_valid),
    .dcache_busy    (dcache_busy),
    .dcache_rdreq   (dcache_rdreq),
    .dcache_wrreq   (dcache_wrreq),
    .dcache_wordlen (dcache_wordlen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  code;
    logic [31:0] rdata;
    int          done_cyc;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Plan shared between the driver and the dcache responder.
  logic        p_rd = 1'b0;
  logic        p_err = 1'b0;
  logic        p_never = 1'b0;
  logic        p_checked = 1'b1;
  logic [31:0] p_word = '0;
  logic [31:0] p_addr = '0;
  logic [31:0] p_din = '0;
  logic [1:0]  p_wl = '0;
  int          p_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic is_bad(input logic [31:0] addr, input logic [2:0] f3);
    int unsigned sz;
    sz = int'(f3) % 4;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (sz == 1 && (addr % 2) != 0) return 1'b1;
    if (sz == 2 && (addr % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t predict(input bit rd, input bit wr, input logic [31:0] addr,
                                   input logic [2:0] f3, input logic [31:0] word,
                                   input int miss, input bit never, input int acc);
    exp_t e;
    logic [31:0] v;
    e.rdata = '0;
    if (rd && wr)               e.code = 2'b10;
    else if (is_bad(addr, f3))  e.code = 2'b01;
    else if (never)             e.code = 2'b11;
    else                        e.code = 2'b00;
    if (e.code == 2'b00 && rd) begin
      case (f3)
        3'd0, 3'd4: begin
          v = (word >> (8 * (addr % 4))) & 32'hFF;
          if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        end
        3'd1, 3'd5: begin
          v = (word >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
          if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        end
        default: v = word;
      endcase
      e.rdata = v;
    end
    if (e.code == 2'b00)      e.done_cyc = acc + 2 + miss;
    else if (e.code == 2'b11) e.done_cyc = acc + TO_LAT;
    else                      e.done_cyc = acc + 1;
    return e;
  endfunction

  function automatic logic [31:0] lanes(input logic [2:0] f3, input logic [31:0] wdata);
    case (int'(f3) % 4)
      0:       return (wdata & 32'hFF) * 32'h0101_0101;
      1:       return (wdata & 32'hFFFF) * 32'h0001_0001;
      default: return wdata;
    endcase
  endfunction

  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wdata, input logic [31:0] word, input int miss,
                        input bit never);
    exp_t e;
    int k;
    @(posedge clk); #1;
    e = predict(rd, wr, addr, f3, word, miss, never, cyc);
    p_rd      = rd;
    p_err     = (e.code == 2'b01 || e.code == 2'b10);
    p_word    = word;
    p_miss    = miss;
    p_never   = never;
    p_addr    = addr;
    p_wl      = f3[1:0];
    p_din     = lanes(f3, wdata);
    p_checked = 1'b0;
    q.push_back(e);
    lsu_rdreq  = rd;
    lsu_wrreq  = wr;
    lsu_addr   = addr;
    lsu_funct3 = f3;
    lsu_wdata  = wdata;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!lsu_done && k < 200);
    if (!lsu_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_wait: no lsu_done within %0d cycles, addr %h", k, addr);
      q.delete();
    end
    lsu_rdreq = 1'b0;
    lsu_wrreq = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  // Scoreboard monitor: compares every completion against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && lsu_done) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got lsu_done with empty scoreboard, expected none");
      end else begin
        e = q.pop_front();
        check("errcode", 32'(lsu_errcode), 32'(e.code));
        check("error", 32'(lsu_error), 32'(e.code != 2'b00));
        check("rdata", lsu_rdata, e.rdata);
        check("latency", 32'(cyc), 32'(e.done_cyc));
        check("busy_at_done", 32'(lsu_busy), 32'd1);
      end
    end
  end

  // Behavioural dcache: busy for p_miss request cycles (valid noise allowed), then hit.
  int acc_n = 0;
  always @(posedge clk) begin
    #1;
    if (dcache_rdreq || dcache_wrreq) begin
      if (!p_checked) begin
        p_checked = 1'b1;
        if (p_err) begin
          n_tests++;
          n_fail++;
          $display("FAIL access_on_error: got dcache request %b/%b, expected none",
                   dcache_rdreq, dcache_wrreq);
        end else begin
          check("rd_dir", 32'(dcache_rdreq), 32'(p_rd));
          check("wr_dir", 32'(dcache_wrreq), 32'(!p_rd));
          check("dcache_addr", dcache_addr, p_addr);
          check("wordlen", 32'(dcache_wordlen), 32'(p_wl));
          if (!p_rd) check("dcache_in", dcache_in, p_din);
        end
      end
      acc_n++;
      dcache_out = p_word;
      if (p_never) begin
        dcache_busy  = 1'($urandom_range(0, 1));
        dcache_valid = 1'b0;
      end else if (acc_n <= p_miss) begin
        dcache_busy  = 1'b1;
        dcache_valid = 1'($urandom_range(0, 1));
      end else begin
        dcache_busy  = 1'b0;
        dcache_valid = 1'b1;
      end
    end else begin
      acc_n        = 0;
      dcache_valid = 1'b0;
      dcache_busy  = 1'b0;
      dcache_out   = $urandom;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    bit          rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          miss;
    bit          never;
    reset_n      = 1'b0;
    lsu_addr     = '0;
    lsu_wdata    = '0;
    lsu_funct3   = '0;
    lsu_rdreq    = 1'b0;
    lsu_wrreq    = 1'b0;
    dcache_out   = '0;
    dcache_valid = 1'b0;
    dcache_busy  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(lsu_done), 32'd0);
    check("rst_error", 32'(lsu_error), 32'd0);
    check("rst_errcode", 32'(lsu_errcode), 32'd0);
    check("rst_busy", 32'(lsu_busy), 32'd0);
    check("rst_rdreq", 32'(dcache_rdreq), 32'd0);
    check("rst_wrreq", 32'(dcache_wrreq), 32'd0);
    check("rst_rdata", lsu_rdata, 32'd0);
    check("rst_addr", dcache_addr, 32'd0);
    check("rst_din", dcache_in, 32'd0);
    check("rst_wordlen", 32'(dcache_wordlen), 32'd0);
    reset_n = 1'b1;

    do_txn(1, 0, 32'h103, 3'b000, 32'h0, 32'h80FF_1234, 0, 0);
    do_txn(1, 0, 32'h102, 3'b101, 32'h0, 32'h8001_0000, 0, 0);
    do_txn(1, 0, 32'h102, 3'b001, 32'h0, 32'h8001_0000, 0, 0);
    do_txn(0, 1, 32'h106, 3'b001, 32'h0000_BEEF, 32'h0, 3, 0);
    do_txn(1, 0, 32'h101, 3'b010, 32'h0, 32'h0, 0, 0);
    do_txn(1, 0, 32'h100, 3'b010, 32'h0, 32'hDEAD_BEEF, 40, 0);
    do_txn(1, 0, 32'h104, 3'b010, 32'h0, 32'h0, 0, 1);
    do_txn(1, 1, 32'h108, 3'b010, 32'h1234_5678, 32'h0, 0, 0);
    do_txn(0, 1, 32'h10B, 3'b000, 32'h0000_00A5, 32'h0, 1, 0);
    do_txn(0, 1, 32'h10C, 3'b011, 32'h0, 32'h0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        rd = 1'b1;
        wr = 1'b1;
      end else begin
        rd = 1'($urandom_range(0, 1));
        wr = !rd;
      end
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else if (rd) begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end else f3 = 3'($urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr = addr & 32'hFFFF_FFFC;
      miss  = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(0, 5);
      never = ($urandom_range(0, 24) == 0);
      do_txn(rd, wr, addr, f3, $urandom, $urandom, miss, never);
    end

    // Reset in the middle of a stalled load must drop the dcache request immediately.
    @(posedge clk); #1;
    p_rd = 1'b1; p_err = 1'b0; p_never = 1'b1; p_checked = 1'b1; p_miss = 0;
    lsu_rdreq  = 1'b1;
    lsu_addr   = 32'h200;
    lsu_funct3 = 3'b010;
    repeat (5) @(negedge clk);
    check("rdreq_before_reset", 32'(dcache_rdreq), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rdreq_at_reset", 32'(dcache_rdreq), 32'd0);
    check("busy_at_reset", 32'(lsu_busy), 32'd0);
    check("errcode_at_reset", 32'(lsu_errcode), 32'd0);
    lsu_rdreq = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    do_txn(1, 0, 32'h204, 3'b100, 32'h0, 32'h1122_33F4, 2, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
